// File: rtl/inst_sequencer.sv
// Fetch/decode/control sequencer: walks the instruction regfile, drives data-regfile controls, issues ops to execute.
// Optional issue watchdog under `SEQ_WDOG_EN` (drops a stalled issue, sets sticky err).
`ifndef LOAD
  `define LOAD  4'h0
  `define STORE 4'h1
  `define MOVE  4'h2
  `define JUMP  4'h3
  `define INV   4'h4
  `define AND   4'h5
  `define OR    4'h6
  `define XOR   4'h7
  `define SHL   4'h8
  `define SHR   4'h9
  `define ROL   4'hA
  `define ROR   4'hB
  `define ADD   4'hC
  `define SUB   4'hD
  `define MUL   4'hE
  `define DIV   4'hF
`endif

module inst_sequencer #(
  parameter int BIT = 16,
  parameter int SZB = 4,
  parameter int SZI = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic [BIT-1:0] inst,
  input  logic [BIT-1:0] rs0_data,
  input  logic           ex_ready,
  output logic [SZI-1:0] addr_inst,
  output logic [SZB-1:0] addr_rs0,
  output logic [SZB-1:0] addr_rs1,
  output logic [SZB-1:0] addr_rd,
  output logic           rd_we,
  output logic           en_mv,
  output logic [3:0]     opcode,
  output logic [7:0]     imm,
  output logic           ex_valid,
  output logic           busy,
  output logic           done,
  output logic           err
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WRITE, S_NEXT
  } state_t;

  localparam logic [SZI-1:0] PC_MAX = '1;

  state_t         state_q, state_d;
  logic [SZI-1:0] pc_q, pc_d;
  logic [BIT-1:0] ir_q, ir_d;

  logic [3:0] op, f2, f1, f0;
  assign op = ir_q[15:12];
  assign f2 = ir_q[11:8];
  assign f1 = ir_q[7:4];
  assign f0 = ir_q[3:0];

  // Only the low SZI bits of a jump target are meaningful.
  logic unused_rs0_hi;
  assign unused_rs0_hi = ^rs0_data[BIT-1:SZI];

`ifdef SEQ_WDOG_EN
  logic [3:0] wdog_q, wdog_d;
  logic       err_q, err_d;
  logic       wdog_expire;

  // Expires on the 15th consecutive unaccepted ISSUE cycle.
  always_comb begin
    wdog_expire = (state_q == S_ISSUE) && !ex_ready && (wdog_q == 4'd14);
    wdog_d      = ((state_q == S_ISSUE) && !ex_ready) ? wdog_q + 4'd1 : 4'd0;
    err_d       = err_q | wdog_expire;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wdog_q <= 4'd0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_FETCH: begin
        ir_d    = inst;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (op == `MOVE) begin
          state_d = S_NEXT;
        end else if (op == `JUMP) begin
          pc_d    = rs0_data[SZI-1:0];
          state_d = S_FETCH;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (ex_ready) begin
          state_d = (op == `STORE) ? S_NEXT : S_WRITE;
        end
`ifdef SEQ_WDOG_EN
        else if (wdog_expire) begin
          state_d = S_IDLE;
        end
`endif
      end
      S_WRITE: state_d = S_NEXT;
      S_NEXT: begin
        if (pc_q == PC_MAX) begin
          state_d = S_IDLE;
        end else begin
          pc_d    = pc_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_inst = pc_q;
    addr_rs0  = '0;
    addr_rs1  = '0;
    addr_rd   = '0;
    opcode    = 4'd0;
    imm       = 8'd0;
    en_mv     = 1'b0;
    rd_we     = 1'b0;
    ex_valid  = 1'b0;
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_NEXT) && (pc_q == PC_MAX);
    if (state_q == S_DECODE || state_q == S_ISSUE || state_q == S_WRITE) begin
      opcode = op;
      case (op)
        `LOAD: begin
          addr_rd = SZB'(f2);
          imm     = ir_q[7:0];
        end
        `STORE: begin
          imm      = ir_q[11:4];
          addr_rs0 = SZB'(f0);
        end
        `MOVE: begin
          addr_rs0 = SZB'(f2);
          addr_rd  = SZB'(f1);
          addr_rs1 = SZB'(f1);
        end
        `JUMP: addr_rs0 = SZB'(f2);
        `INV: begin
          addr_rd  = SZB'(f2);
          addr_rs0 = SZB'(f1);
        end
        default: begin
          addr_rd  = SZB'(f2);
          addr_rs0 = SZB'(f1);
          addr_rs1 = SZB'(f0);
        end
      endcase
      en_mv    = (state_q == S_DECODE) && (op == `MOVE);
      ex_valid = (state_q == S_ISSUE);
      rd_we    = (state_q == S_WRITE);
    end
  end

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed-vector bench for inst_sequencer; watchdog expectations follow SEQ_WDOG_EN.
module tb_inst_sequencer;

  localparam logic [3:0] OP_LOAD  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_MOVE  = 4'h2;
  localparam logic [3:0] OP_JUMP  = 4'h3;
  localparam logic [3:0] OP_ADD   = 4'hC;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        ex_ready = 1'b0;
  logic [15:0] inst, rs0_data;
  logic [3:0]  addr_inst, addr_rs0, addr_rs1, addr_rd, opcode;
  logic [7:0]  imm;
  logic        rd_we, en_mv, ex_valid, busy, done, err;

  logic [15:0] imem [16];
  logic [15:0] regs [16];

  int checks = 0;
  int failures = 0;

  assign inst     = imem[addr_inst];
  assign rs0_data = regs[addr_rs0];

  always #5 clock = ~clock;

  inst_sequencer #(.BIT(16), .SZB(4), .SZI(4)) dut (
    .clock(clock), .reset(reset), .start(start), .inst(inst),
    .rs0_data(rs0_data), .ex_ready(ex_ready), .addr_inst(addr_inst),
    .addr_rs0(addr_rs0), .addr_rs1(addr_rs1), .addr_rd(addr_rd),
    .rd_we(rd_we), .en_mv(en_mv), .opcode(opcode), .imm(imm),
    .ex_valid(ex_valid), .busy(busy), .done(done), .err(err)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic load_prog(input logic [15:0] w0, input logic [15:0] rest);
    imem[0] = w0;
    for (int i = 1; i < 16; i++) imem[i] = rest;
  endtask

  task automatic kick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  int vcnt, dcnt;
  logic seen;
  logic [3:0] pc_at_done;

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 16'h0;
    regs[2] = 16'h0009;
    regs[3] = 16'hFFF5;
    load_prog(16'h0, 16'h0);

    // Reset state
    do_reset();
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_ex_valid", ex_valid, 0);
    chk_eq("rst_addr_inst", addr_inst, 0);
    chk_eq("rst_rd_we", rd_we, 0);
    chk_eq("rst_done", done, 0);
    chk_eq("rst_err", err, 0);

    // 1: LOAD r3, 0xA5 with ex_ready high
    load_prog({OP_LOAD, 4'd3, 8'hA5}, 16'h0);
    ex_ready = 1'b1;
    kick();
    chk_eq("t1_fetch_addr", addr_inst, 0);
    chk_eq("t1_fetch_busy", busy, 1);
    tick();
    chk_eq("t1_dec_valid", ex_valid, 0);
    tick();
    chk_eq("t1_iss_valid", ex_valid, 1);
    chk_eq("t1_iss_op", opcode, OP_LOAD);
    chk_eq("t1_iss_imm", imm, 8'hA5);
    chk_eq("t1_iss_rd", addr_rd, 3);
    tick();
    chk_eq("t1_wr_we", rd_we, 1);
    chk_eq("t1_wr_rd", addr_rd, 3);
    chk_eq("t1_wr_valid", ex_valid, 0);
    tick();
    chk_eq("t1_next_we", rd_we, 0);
    tick();
    chk_eq("t1_fetch1_addr", addr_inst, 1);
    do_reset();

    // 2: ADD r11 = r3 + r2, execute stalls 4 cycles
    load_prog({OP_ADD, 4'd11, 4'd3, 4'd2}, 16'h0);
    ex_ready = 1'b0;
    kick();
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk_eq("t2_valid", ex_valid, 1);
      chk_eq("t2_rs0", addr_rs0, 3);
      chk_eq("t2_rs1", addr_rs1, 2);
      chk_eq("t2_rd", addr_rd, 11);
      chk_eq("t2_no_we", rd_we, 0);
      if (i == 4) ex_ready = 1'b1;
      tick();
    end
    chk_eq("t2_wr_we", rd_we, 1);
    chk_eq("t2_wr_valid", ex_valid, 0);
    tick();
    chk_eq("t2_we_single", rd_we, 0);
    do_reset();

    // 3: MOVE r2 <- r0
    load_prog({OP_MOVE, 4'd0, 4'd2, 4'd0}, 16'h0);
    kick();
    tick();
    chk_eq("t3_en_mv", en_mv, 1);
    chk_eq("t3_rs0", addr_rs0, 0);
    chk_eq("t3_rd", addr_rd, 2);
    chk_eq("t3_rs1", addr_rs1, 2);
    chk_eq("t3_dec_valid", ex_valid, 0);
    chk_eq("t3_dec_we", rd_we, 0);
    tick();
    chk_eq("t3_next_mv", en_mv, 0);
    chk_eq("t3_next_we", rd_we, 0);
    tick();
    chk_eq("t3_fetch1_addr", addr_inst, 1);
    do_reset();

    // 4a: JUMP truncates target 0xFFF5 to 5
    load_prog({OP_JUMP, 4'd3, 8'h00}, {OP_MOVE, 4'd0, 4'd2, 4'd0});
    kick();
    tick();
    tick();
    chk_eq("t4_trunc_addr", addr_inst, 5);
    do_reset();

    // 4b: JUMP to 9, MOVEs to end of program, one done pulse
    load_prog({OP_JUMP, 4'd2, 8'h00}, {OP_MOVE, 4'd0, 4'd2, 4'd0});
    kick();
    tick();
    tick();
    chk_eq("t4_jump_addr", addr_inst, 9);
    dcnt = 0;
    seen = 1'b0;
    pc_at_done = 4'd0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (done) begin
        dcnt++;
        seen = 1'b1;
        pc_at_done = addr_inst;
        start = 1'b1;
        tick();
        start = 1'b0;
      end else begin
        tick();
      end
    end
    chk_eq("t4_done_seen", seen, 1);
    chk_eq("t4_done_pc", pc_at_done, 15);
    chk_eq("t4_busy_after", busy, 0);
    for (int i = 0; i < 5; i++) begin
      if (done) dcnt++;
      tick();
    end
    chk_eq("t4_done_count", dcnt, 1);
    chk_eq("t4_start_ignored", busy, 0);
    do_reset();

    // 5: reset mid-handshake
    load_prog({OP_ADD, 4'd11, 4'd3, 4'd2}, 16'h0);
    ex_ready = 1'b0;
    kick();
    tick();
    tick();
    chk_eq("t5_pre_valid", ex_valid, 1);
    reset = 1'b1;
    tick();
    chk_eq("t5_valid", ex_valid, 0);
    chk_eq("t5_busy", busy, 0);
    chk_eq("t5_rd", addr_rd, 0);
    chk_eq("t5_op", opcode, 0);
    reset = 1'b0;
    kick();
    chk_eq("t5_restart_addr", addr_inst, 0);
    chk_eq("t5_restart_busy", busy, 1);
    do_reset();

    // 6: STORE with execute never ready
    load_prog({OP_STORE, 8'h5A, 4'd7}, 16'h0);
    ex_ready = 1'b0;
    kick();
    tick();
    tick();
    chk_eq("t6_op", opcode, OP_STORE);
    chk_eq("t6_imm", imm, 8'h5A);
    chk_eq("t6_rs0", addr_rs0, 7);
    vcnt = 0;
    dcnt = 0;
    for (int i = 0; i < 120; i++) begin
      if (ex_valid) vcnt++;
      if (done) dcnt++;
      tick();
    end
    chk_eq("t6_no_done", dcnt, 0);
`ifdef SEQ_WDOG_EN
    chk_eq("t6_valid_cycles", vcnt, 15);
    chk_eq("t6_err", err, 1);
    chk_eq("t6_idle", busy, 0);
    kick();
    chk_eq("t6_restart_busy", busy, 1);
    chk_eq("t6_err_sticky", err, 1);
`else
    chk_eq("t6_valid_cycles", vcnt, 120);
    chk_eq("t6_valid_held", ex_valid, 1);
    chk_eq("t6_err", err, 0);
`endif
    do_reset();
    chk_eq("t6_err_cleared", err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
